// File: rtl/load_mb_pp_if.sv
// ---------------------------------------------------------------------------
// load_mb_pp_if
//   Pixel beat stream into the macroblock loader (valid/ready handshake).
//   A beat transfers on a rising clk edge when pvalid and pready are both high.
// Signals
//   pvalid  master -> slave  beat valid
//   pready  slave -> master  loader accepts a beat
//   pdata   master -> slave  W-bit beat, first sample in the MSBs
// Modports
//   master  pixel source side
//   slave   loader side
// ---------------------------------------------------------------------------
interface load_mb_pp_if #(
  parameter int W = 64
);
  logic         pvalid;
  logic         pready;
  logic [W-1:0] pdata;

  modport master (output pvalid, output pdata, input  pready);
  modport slave  (input  pvalid, input  pdata, output pready);
endinterface

// File: rtl/load_mb_pp.sv
// ---------------------------------------------------------------------------
// load_mb_pp
//   Macroblock loader. Pixel beats stream into a fill buffer; once a complete
//   macroblock has arrived the loader holds it (FULL) until the pipeline takes
//   it with mb_switch, which copies the whole fill buffer into the stable
//   output buffer in one cycle. Luma beats come first, then (4:2:0 only)
//   chroma beats carrying interleaved U,V pairs.
// Parameters
//   BIT_DEPTH     bits per sample (8..10)
//   PIX_PER_BEAT  samples per beat (4, 8 or 16)
//   CHROMA_EN     1: 4:2:0 with U/V after luma, 0: luma only
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   load_start    request loading of the next MB (level or pulse)
//   load_abort    discard the MB currently being loaded
//   pix           pixel beat stream (slave side)
//   load_done     1-cycle pulse when the fill buffer becomes complete
//   buf_full      fill buffer complete and not yet switched
//   mb_switch     pipeline takes the MB (fill -> output copy)
//   out_valid     output buffer holds a valid MB (sticky)
//   cur_y_o       16x16 luma raster, sample j at [(j+1)*BD-1 : j*BD]
//   cur_u_o       8x8 Cb raster, same packing (0 when luma only)
//   cur_v_o       8x8 Cr raster, same packing (0 when luma only)
// ---------------------------------------------------------------------------
module load_mb_pp #(
  parameter int BIT_DEPTH    = 8,
  parameter int PIX_PER_BEAT = 8,
  parameter int CHROMA_EN    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_start,
  input  logic                    load_abort,
  load_mb_pp_if.slave             pix,
  output logic                    load_done,
  output logic                    buf_full,
  input  logic                    mb_switch,
  output logic                    out_valid,
  output logic [256*BIT_DEPTH-1:0] cur_y_o,
  output logic [64*BIT_DEPTH-1:0]  cur_u_o,
  output logic [64*BIT_DEPTH-1:0]  cur_v_o
);

  localparam int BD   = BIT_DEPTH;
  localparam int PPB  = PIX_PER_BEAT;
  localparam int HALF = PPB / 2;
  localparam int NY   = 256 / PPB;
  localparam int NC   = (CHROMA_EN != 0) ? 128 / PPB : 0;
  localparam int NB   = NY + NC;
  localparam int CW   = $clog2(NB);

  localparam logic [CW-1:0] LAST_BEAT = CW'(NB - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FULL
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          pready_q;
  logic          load_done_q;
  logic          buf_full_q;
  logic          out_valid_q;

  logic [BD-1:0] fill_y_q [256];
  logic [BD-1:0] fill_u_q [64];
  logic [BD-1:0] fill_v_q [64];
  logic [BD-1:0] out_y_q  [256];
  logic [BD-1:0] out_u_q  [64];
  logic [BD-1:0] out_v_q  [64];

  logic p_en;
  logic wr_en;
  logic take;
  logic is_chroma;
  int   y_base;
  int   c_base;

  assign p_en  = pix.pvalid & pready_q;
  // An abort in the same cycle as a beat wins; the beat is dropped.
  assign wr_en = p_en & (state_q == LOAD) & ~load_abort;
  assign take  = (state_q == FULL) & mb_switch;

  assign is_chroma = (CHROMA_EN != 0) && (int'(cnt_q) >= NY);
  assign y_base    = int'(cnt_q) * PPB;
  assign c_base    = (int'(cnt_q) - NY) * HALF;

  // Control FSM. Every output is a register so downstream sees clean levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pready_q    <= 1'b0;
      load_done_q <= 1'b0;
      buf_full_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments on all state so every register samples
      // pre-edge values regardless of statement order.
      load_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_start) begin
            state_q  <= LOAD;
            pready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (load_abort) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            pready_q <= 1'b0;
          end else if (p_en) begin
            if (cnt_q == LAST_BEAT) begin
              // pready drops with the edge that takes the last beat, so no
              // beat beyond NB can be accepted.
              state_q     <= FULL;
              cnt_q       <= '0;
              pready_q    <= 1'b0;
              load_done_q <= 1'b1;
              buf_full_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        FULL: begin
          if (mb_switch) begin
            buf_full_q  <= 1'b0;
            out_valid_q <= 1'b1;
            if (load_start) begin
              state_q  <= LOAD;
              pready_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sample buffers. Luma beats land in raster order; a chroma beat carries
  // PPB/2 U,V pairs, U first, starting at the MSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these buffers are reset explicitly because the outputs must read
      // 0 after reset; a plain storage array would normally be left unreset.
      for (int j = 0; j < 256; j++) begin
        fill_y_q[j] <= '0;
        out_y_q[j]  <= '0;
      end
      for (int i = 0; i < 64; i++) begin
        fill_u_q[i] <= '0;
        fill_v_q[i] <= '0;
        out_u_q[i]  <= '0;
        out_v_q[i]  <= '0;
      end
    end else begin
      if (wr_en) begin
        if (!is_chroma) begin
          for (int s = 0; s < PPB; s++) begin
            fill_y_q[8'(y_base + s)] <= pix.pdata[(PPB-1-s)*BD +: BD];
          end
        end else begin
          for (int i = 0; i < HALF; i++) begin
            fill_u_q[6'(c_base + i)] <= pix.pdata[(PPB-1-2*i)*BD +: BD];
            fill_v_q[6'(c_base + i)] <= pix.pdata[(PPB-2-2*i)*BD +: BD];
          end
        end
      end
      if (take) begin
        out_y_q <= fill_y_q;
        out_u_q <= fill_u_q;
        out_v_q <= fill_v_q;
      end
    end
  end

  assign pix.pready = pready_q;
  assign load_done  = load_done_q;
  assign buf_full   = buf_full_q;
  assign out_valid  = out_valid_q;

  for (genvar j = 0; j < 256; j++) begin : g_y
    assign cur_y_o[j*BD +: BD] = out_y_q[j];
  end
  for (genvar i = 0; i < 64; i++) begin : g_uv
    assign cur_u_o[i*BD +: BD] = out_u_q[i];
    assign cur_v_o[i*BD +: BD] = out_v_q[i];
  end

endmodule

// File: tb/tb_load_mb_pp.sv
// ---------------------------------------------------------------------------
// tb_load_mb_pp
//   Bench for load_mb_pp. Main instance: 8-bit, 8 samples/beat, 4:2:0 (48
//   beats). Second instance: 10-bit, 16 samples/beat, luma only (16 beats).
//   Expected buffers come from the flat sample stream of each MB: luma is the
//   first 256 samples, then U and V alternate.
// ---------------------------------------------------------------------------
module tb_load_mb_pp;

  localparam int BD   = 8;
  localparam int PPB  = 8;
  localparam int NB   = 48;
  localparam int W    = BD * PPB;
  localparam int BDL  = 10;
  localparam int PPBL = 16;
  localparam int NBL  = 16;
  localparam int WL   = BDL * PPBL;
  localparam int VW   = 2560;

  typedef logic [VW-1:0] vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Main instance
  load_mb_pp_if #(.W(W)) pif ();
  logic              load_start = 1'b0;
  logic              load_abort = 1'b0;
  logic              mb_switch  = 1'b0;
  logic              load_done, buf_full, out_valid;
  logic [256*BD-1:0] cur_y;
  logic [64*BD-1:0]  cur_u, cur_v;

  load_mb_pp #(.BIT_DEPTH(BD), .PIX_PER_BEAT(PPB), .CHROMA_EN(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_abort (load_abort),
    .pix        (pif.slave),
    .load_done  (load_done),
    .buf_full   (buf_full),
    .mb_switch  (mb_switch),
    .out_valid  (out_valid),
    .cur_y_o    (cur_y),
    .cur_u_o    (cur_u),
    .cur_v_o    (cur_v)
  );

  // Luma-only instance
  load_mb_pp_if #(.W(WL)) lif ();
  logic               l_start  = 1'b0;
  logic               l_abort  = 1'b0;
  logic               l_switch = 1'b0;
  logic               l_done, l_full, l_valid;
  logic [256*BDL-1:0] l_y;
  logic [64*BDL-1:0]  l_u, l_v;

  load_mb_pp #(.BIT_DEPTH(BDL), .PIX_PER_BEAT(PPBL), .CHROMA_EN(0)) dut_l (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (l_start),
    .load_abort (l_abort),
    .pix        (lif.slave),
    .load_done  (l_done),
    .buf_full   (l_full),
    .mb_switch  (l_switch),
    .out_valid  (l_valid),
    .cur_y_o    (l_y),
    .cur_u_o    (l_u),
    .cur_v_o    (l_v)
  );

  // Reference model state
  int                smp  [384];
  int                smpl [256];
  logic [256*BD-1:0] exp_y = '0;
  logic [64*BD-1:0]  exp_u = '0;
  logic [64*BD-1:0]  exp_v = '0;

  // Transfer and pulse monitors
  int acc_cnt   = 0;
  int done_cnt  = 0;
  int l_acc_cnt = 0;
  int l_dones   = 0;

  always @(posedge clk) begin
    if (rst_n && pif.pvalid === 1'b1 && pif.pready === 1'b1) acc_cnt++;
    if (rst_n && lif.pvalid === 1'b1 && lif.pready === 1'b1) l_acc_cnt++;
  end

  always @(negedge clk) begin
    if (load_done === 1'b1) done_cnt++;
    if (l_done === 1'b1) l_dones++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    int lo;
    checks++;
    assert (obs === exp) else begin
      failures++;
      lo = 0;
      for (int i = VW - 1; i >= 0; i--) if (obs[i] !== exp[i]) lo = i;
      if (lo > VW - 32) lo = VW - 32;
      $error("FAIL %s: got %h want %h (32-bit window at bit %0d)", tag,
             obs[lo +: 32], exp[lo +: 32], lo);
    end
  endtask

  function automatic logic [W-1:0] beat_word(input int b);
    logic [W-1:0] w;
    w = '0;
    for (int s = 0; s < PPB; s++) w[(PPB-1-s)*BD +: BD] = BD'(smp[b*PPB + s]);
    return w;
  endfunction

  function automatic logic [WL-1:0] lbeat_word(input int b);
    logic [WL-1:0] w;
    w = '0;
    for (int s = 0; s < PPBL; s++) w[(PPBL-1-s)*BDL +: BDL] = BDL'(smpl[b*PPBL + s]);
    return w;
  endfunction

  task automatic fill_random();
    for (int n = 0; n < 384; n++) smp[n] = int'($urandom_range(0, 255));
  endtask

  // Output buffer expected after switching in the MB currently in smp.
  task automatic latch_expected();
    for (int j = 0; j < 256; j++) exp_y[j*BD +: BD] = BD'(smp[j]);
    for (int i = 0; i < 64; i++) begin
      exp_u[i*BD +: BD] = BD'(smp[256 + 2*i]);
      exp_v[i*BD +: BD] = BD'(smp[257 + 2*i]);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_y"}, vec_t'(cur_y), vec_t'(exp_y));
    check({tag, "_u"}, vec_t'(cur_u), vec_t'(exp_u));
    check({tag, "_v"}, vec_t'(cur_v), vec_t'(exp_v));
  endtask

  task automatic start_load();
    @(negedge clk);
    load_start = 1'b1;
    pif.pvalid = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
    check("ready_after_start", vec_t'(pif.pready), vec_t'(1));
  endtask

  // Offers beats first..first+n-1; rnd inserts random idle cycles.
  task automatic stream(input bit rnd, input int n, input int first);
    int b;
    int cyc;
    b   = first;
    cyc = 0;
    while (b < first + n && cyc < 4000) begin
      @(negedge clk);
      pif.pvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pif.pdata  = beat_word(b);
      if (pif.pvalid && pif.pready) b++;
      cyc++;
    end
    check("stream_budget", vec_t'(cyc < 4000), vec_t'(1));
  endtask

  // Called right after the last beat was offered.
  task automatic finish_mb(input int acc0, input int d0);
    @(negedge clk);
    check("done_after_last", vec_t'(load_done), vec_t'(1));
    check("ready_drop", vec_t'(pif.pready), vec_t'(0));
    check("buf_full_set", vec_t'(buf_full), vec_t'(1));
    pif.pvalid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ready_held_low", vec_t'(pif.pready), vec_t'(0));
      check("done_single", vec_t'(load_done), vec_t'(0));
    end
    pif.pvalid = 1'b0;
    check("beats_accepted", vec_t'(acc_cnt - acc0), vec_t'(NB));
    check("done_count", vec_t'(done_cnt - d0), vec_t'(1));
  endtask

  task automatic switch_mb(input bit with_start);
    latch_expected();
    @(negedge clk);
    mb_switch  = 1'b1;
    load_start = with_start;
    load_abort = 1'b0;
    pif.pvalid = 1'b0;
    @(negedge clk);
    mb_switch  = 1'b0;
    load_start = 1'b0;
    check("out_valid_set", vec_t'(out_valid), vec_t'(1));
    check("buf_full_clr", vec_t'(buf_full), vec_t'(0));
    check("ready_after_switch", vec_t'(pif.pready), vec_t'(with_start));
    check_outputs("switch");
  endtask

  initial begin
    int acc0;
    int d0;
    vec_t exp_ly;

    pif.pvalid = 1'b0;
    pif.pdata  = '0;
    lif.pvalid = 1'b0;
    lif.pdata  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pready", vec_t'(pif.pready), vec_t'(0));
    check("rst_done", vec_t'(load_done), vec_t'(0));
    check("rst_full", vec_t'(buf_full), vec_t'(0));
    check("rst_out_valid", vec_t'(out_valid), vec_t'(0));
    check_outputs("rst");
    rst_n = 1'b1;

    // Stray switch in IDLE before any MB
    @(negedge clk);
    mb_switch = 1'b1;
    @(negedge clk);
    mb_switch = 1'b0;
    check("stray_idle0_valid", vec_t'(out_valid), vec_t'(0));
    check_outputs("stray_idle0");

    // Index pattern: every sample of beat b equals b
    for (int n = 0; n < 384; n++) smp[n] = n / PPB;
    acc0 = acc_cnt;
    d0   = done_cnt;
    start_load();
    stream(1'b0, NB, 0);
    finish_mb(acc0, d0);
    switch_mb(1'b0);
    check("index_y255", vec_t'(cur_y[255*BD +: BD]), vec_t'(31));
    check("index_u63", vec_t'(cur_u[63*BD +: BD]), vec_t'(47));
    check("index_v0", vec_t'(cur_v[0 +: BD]), vec_t'(32));

    // Random data with random backpressure
    fill_random();
    acc0 = acc_cnt;
    d0   = done_cnt;
    start_load();
    stream(1'b1, NB, 0);
    finish_mb(acc0, d0);
    switch_mb(1'b0);

    // Abort after 20 beats, then a fresh load
    fill_random();
    d0 = done_cnt;
    start_load();
    stream(1'b0, 20, 0);
    @(negedge clk);
    load_abort = 1'b1;
    pif.pvalid = 1'b1;
    pif.pdata  = beat_word(20);
    @(negedge clk);
    load_abort = 1'b0;
    pif.pvalid = 1'b0;
    check("abort_ready", vec_t'(pif.pready), vec_t'(0));
    check("abort_full", vec_t'(buf_full), vec_t'(0));
    repeat (3) @(negedge clk);
    check("abort_no_done", vec_t'(done_cnt - d0), vec_t'(0));
    check("abort_out_valid", vec_t'(out_valid), vec_t'(1));
    check_outputs("abort_hold");
    fill_random();
    acc0 = acc_cnt;
    d0   = done_cnt;
    start_load();
    stream(1'b1, NB, 0);
    finish_mb(acc0, d0);
    switch_mb(1'b0);

    // Hold a full MB for 100 cycles while poking start/abort
    fill_random();
    acc0 = acc_cnt;
    d0   = done_cnt;
    start_load();
    stream(1'b0, NB, 0);
    finish_mb(acc0, d0);
    d0 = done_cnt;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check("hold_ready", vec_t'(pif.pready), vec_t'(0));
      check("hold_full", vec_t'(buf_full), vec_t'(1));
      load_start = 1'($urandom_range(0, 1));
      load_abort = 1'($urandom_range(0, 1));
      pif.pvalid = 1'b1;
    end
    check("hold_no_done", vec_t'(done_cnt - d0), vec_t'(0));
    switch_mb(1'b1);

    // Next MB starts straight from the switch; stray switch mid-load
    fill_random();
    acc0 = acc_cnt;
    d0   = done_cnt;
    stream(1'b0, 10, 0);
    @(negedge clk);
    mb_switch  = 1'b1;
    pif.pvalid = 1'b0;
    @(negedge clk);
    mb_switch = 1'b0;
    check("stray_load_ready", vec_t'(pif.pready), vec_t'(1));
    check("stray_load_valid", vec_t'(out_valid), vec_t'(1));
    check_outputs("stray_load");
    stream(1'b1, NB - 10, 10);
    finish_mb(acc0, d0);
    switch_mb(1'b0);

    // Stray switch in IDLE with a valid output buffer
    @(negedge clk);
    mb_switch = 1'b1;
    @(negedge clk);
    mb_switch = 1'b0;
    check("stray_idle_valid", vec_t'(out_valid), vec_t'(1));
    check_outputs("stray_idle");

    // Luma-only instance: 16 beats of 16 ten-bit samples
    for (int n = 0; n < 256; n++) smpl[n] = int'($urandom_range(0, 1023));
    @(negedge clk);
    l_start = 1'b1;
    @(negedge clk);
    l_start = 1'b0;
    check("l_ready_start", vec_t'(lif.pready), vec_t'(1));
    for (int b = 0; b < NBL; b++) begin
      lif.pvalid = 1'b1;
      lif.pdata  = lbeat_word(b);
      @(negedge clk);
      if (b < NBL - 1) check("l_no_early_done", vec_t'(l_done), vec_t'(0));
    end
    check("l_done", vec_t'(l_done), vec_t'(1));
    check("l_ready_drop", vec_t'(lif.pready), vec_t'(0));
    check("l_full", vec_t'(l_full), vec_t'(1));
    repeat (2) @(negedge clk);
    lif.pvalid = 1'b0;
    check("l_done_count", vec_t'(l_dones), vec_t'(1));
    check("l_beats", vec_t'(l_acc_cnt), vec_t'(NBL));
    l_switch = 1'b1;
    @(negedge clk);
    l_switch = 1'b0;
    exp_ly = '0;
    for (int j = 0; j < 256; j++) exp_ly[j*BDL +: BDL] = BDL'(smpl[j]);
    check("l_out_valid", vec_t'(l_valid), vec_t'(1));
    check("l_y", vec_t'(l_y), exp_ly);
    check("l_u_zero", vec_t'(l_u), vec_t'(0));
    check("l_v_zero", vec_t'(l_v), vec_t'(0));

    // Reset in the middle of a load
    fill_random();
    start_load();
    stream(1'b0, 10, 0);
    @(negedge clk);
    pif.pvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_pready", vec_t'(pif.pready), vec_t'(0));
    check("mrst_done", vec_t'(load_done), vec_t'(0));
    check("mrst_full", vec_t'(buf_full), vec_t'(0));
    check("mrst_out_valid", vec_t'(out_valid), vec_t'(0));
    check("mrst_y", vec_t'(cur_y), vec_t'(0));
    check("mrst_u", vec_t'(cur_u), vec_t'(0));
    check("mrst_v", vec_t'(cur_v), vec_t'(0));
    check("mrst_l_y", vec_t'(l_y), vec_t'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", vec_t'(pif.pready), vec_t'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
